// File: rtl/brick_pkg.sv
// brick_pkg: geometry defaults, width derivations, FSM encoding and the
// initial hit-point rule shared by the brick wall engine.
package brick_pkg;

  localparam int DEF_BRICKS_H     = 16;
  localparam int DEF_BRICKS_V     = 8;
  localparam int DEF_BRICK_W_LOG2 = 4;
  localparam int DEF_BRICK_H_LOG2 = 3;
  localparam int DEF_FIELD_X      = 0;
  localparam int DEF_FIELD_Y      = 64;
  localparam int DEF_LOAD_PHASE   = 8;
  localparam int DEF_HITS_W       = 2;
  localparam int DEF_STRONG_ROWS  = 2;

  typedef enum logic {
    INIT = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int hits_max(input int hits_w);
    return (1 << hits_w) - 1;
  endfunction

  function automatic int cnt_w(input int bh, input int bv);
    return $clog2(bh * bv + 1);
  endfunction

  function automatic int init_hits(
    input int row,
    input int strong_rows,
    input int hmax
  );
    return (row < strong_rows) ? hmax : 1;
  endfunction

endpackage

// File: rtl/brick_field_scanner_ram.sv
// brick_ram: hit-point store, one write port and one asynchronous read
// port; a same-address write is forwarded to the read port.
module brick_ram
  import brick_pkg::*;
#(
  parameter int DEPTH = DEF_BRICKS_H * DEF_BRICKS_V,
  parameter int WIDTH = DEF_HITS_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];

endmodule

// File: rtl/brick_field_scanner.sv
// brick_field_scanner: multi-hit brick wall scanned with the beam.
// Optional BRICK_ROW_POINTS_EN scores hits by row instead of a flat 1.
module brick_field_scanner
  import brick_pkg::*;
#(
  parameter int BRICKS_H     = DEF_BRICKS_H,
  parameter int BRICKS_V     = DEF_BRICKS_V,
  parameter int BRICK_W_LOG2 = DEF_BRICK_W_LOG2,
  parameter int BRICK_H_LOG2 = DEF_BRICK_H_LOG2,
  parameter int FIELD_X      = DEF_FIELD_X,
  parameter int FIELD_Y      = DEF_FIELD_Y,
  parameter int LOAD_PHASE   = DEF_LOAD_PHASE,
  parameter int HITS_W       = DEF_HITS_W,
  parameter int STRONG_ROWS  = DEF_STRONG_ROWS,
  localparam int HITS_MAX    = hits_max(HITS_W),
  localparam int CNT_W       = cnt_w(BRICKS_H, BRICKS_V)
) (
  input  logic              visible_clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              frame_start,
  input  logic              reload,
  input  logic              ball_gfx,
  output logic              brick_present,
  output logic              brick_gfx,
  output logic [HITS_W-1:0] brick_hits,
  output logic              score_pulse,
  output logic [3:0]        score_pts,
  output logic [CNT_W-1:0]  bricks_left,
  output logic              field_clear,
  output logic              init_busy
);

  localparam int N  = BRICKS_H * BRICKS_V;
  localparam int AW = $clog2(N);
  localparam int CW = (BRICKS_H > 1) ? $clog2(BRICKS_H) : 1;
  localparam int RW = (BRICKS_V > 1) ? $clog2(BRICKS_V) : 1;
  localparam int FW = BRICKS_H << BRICK_W_LOG2;
  localparam int FH = BRICKS_V << BRICK_H_LOG2;

  state_t state, state_n;

  logic [9:0]        rel_x, rel_y;
  logic              in_field, load, scan, hit;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [AW-1:0]     index, idx, init_addr;
  logic              init_last;
  logic              hit_lock;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [HITS_W-1:0] wdata, rdata, new_hits, init_val;

  // 10-bit offsets: bit 9 flags a beam left of / above the field
  assign rel_x    = {1'b0, hpos} - 10'(FIELD_X);
  assign rel_y    = {1'b0, vpos} - 10'(FIELD_Y);
  assign in_field = !rel_x[9] && rel_x < 10'(FW) &&
                    !rel_y[9] && rel_y < 10'(FH);
  assign col      = rel_x[BRICK_W_LOG2 +: CW];
  assign row      = rel_y[BRICK_H_LOG2 +: RW];
  assign index    = AW'(row) * AW'(BRICKS_H) + AW'(col);
  assign load     = in_field &&
    hpos[BRICK_W_LOG2-1:0] == BRICK_W_LOG2'(LOAD_PHASE);

  assign scan      = state == SCAN;
  assign init_last = init_addr == AW'(N - 1);
  assign new_hits  = brick_hits - HITS_W'(1);
  assign init_val  = HITS_W'(init_hits(
    int'(init_addr) / BRICKS_H, STRONG_ROWS, HITS_MAX));
  assign hit = ball_gfx && brick_present && !hit_lock &&
               scan && !reload;

  assign we    = (!scan && !reload) || hit;
  assign waddr = scan ? idx : init_addr;
  assign wdata = scan ? new_hits : init_val;

  brick_ram #(
    .DEPTH (N),
    .WIDTH (HITS_W)
  ) u_ram (
    .clk   (visible_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (index),
    .rdata (rdata)
  );

  always_ff @(posedge visible_clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    init_busy     = 1'b0;
    brick_present = 1'b0;
    field_clear   = 1'b0;
    unique case (state)
      INIT: begin
        init_busy = 1'b1;
        if (!reload && init_last) state_n = SCAN;
      end
      SCAN: begin
        brick_present = brick_hits != '0;
        field_clear   = bricks_left == '0;
        if (reload) state_n = INIT;
      end
    endcase
  end

  assign brick_gfx = brick_present &&
    vpos[BRICK_H_LOG2-1:0] != '0 &&
    hpos[BRICK_W_LOG2-1:1] != (BRICK_W_LOG2-1)'(LOAD_PHASE >> 1);

  always_ff @(posedge visible_clk or posedge reset) begin
    if (reset) begin
      init_addr   <= '0;
      bricks_left <= '0;
      hit_lock    <= 1'b0;
      score_pulse <= 1'b0;
      brick_hits  <= '0;
      idx         <= '0;
    end else begin
      score_pulse <= hit;
      if (load) idx <= index;
      if (scan || reload || init_last) init_addr <= '0;
      else                             init_addr <= init_addr + AW'(1);
      if (reload)
        bricks_left <= '0;
      else if (!scan)
        bricks_left <= bricks_left + CNT_W'(1);
      else if (hit && new_hits == '0 && bricks_left != '0)
        bricks_left <= bricks_left - CNT_W'(1);
      // a hit in the same cycle as frame_start keeps the lock
      if (reload)           hit_lock <= 1'b0;
      else if (hit)         hit_lock <= 1'b1;
      else if (frame_start) hit_lock <= 1'b0;
      if (!scan || reload || !in_field) brick_hits <= '0;
      else if (load)                    brick_hits <= rdata;
      else if (hit)                     brick_hits <= new_hits;
    end
  end

`ifdef BRICK_ROW_POINTS_EN
  always_ff @(posedge visible_clk or posedge reset) begin
    if (reset)    score_pts <= '0;
    else if (hit) score_pts <= 4'(BRICKS_V - int'(idx) / BRICKS_H);
  end
`else
  assign score_pts = 4'd1;
`endif

endmodule
